data_memory_sized: RTL
======================

DATA_MEMORY_SIZED -- requirements
Module: data_memory_sized

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words (power of two, 4..65536).
REQ-002 SHALL have parameter INIT_ZERO, default 0; when 1, every word is cleared at reset, one word per cycle.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-006 SHALL have port req_ready, output, 1 bit: the block accepts the request this cycle.
REQ-007 SHALL have port MemWrite, input, 1 bit: 1 means store, 0 means load.
REQ-008 SHALL have port size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 SHALL have port unsigned_ld, input, 1 bit: 1 means zero-extend loads, 0 means sign-extend.
REQ-010 SHALL have port address, input, 32 bits: byte address, little-endian.
REQ-011 SHALL have port writeData, input, 32 bits: store data, right-aligned (bits [7:0] for byte, [15:0] for half).
REQ-012 SHALL have port resp_valid, output, 1 bit: a response is held.
REQ-013 SHALL have port resp_ready, input, 1 bit: the consumer takes the response.
REQ-014 SHALL have port readData, output, 32 bits: load result, extended; 0 for stores and errors.
REQ-015 SHALL have port resp_err, output, 1 bit: the request was misaligned, out of range or of illegal size.

Function
REQ-016 SHALL accept a request when req_valid && req_ready (handshake); inputs are sampled only on acceptance.
REQ-017 SHALL drive req_ready = !busy_init && (!resp_valid || resp_ready), i.e. a one-entry output buffer with same-cycle pass-through of the pop.
REQ-018 SHALL assert resp_valid exactly one cycle after acceptance and hold resp_valid, readData and resp_err stable until resp_valid && resp_ready.
REQ-019 SHALL let back-to-back requests sustain one per cycle while resp_ready is held at 1.
REQ-020 SHALL compute word index = address[log2(DEPTH)+1:2] and lane = address[1:0].
REQ-021 SHALL flag an error when any of the following holds: size==11; half with address[0]!=0; word with address[1:0]!=0; address >= 4*DEPTH.
REQ-022 SHALL, on an errored request, leave memory unmodified and still respond, with resp_err=1 and readData=0.
REQ-023 SHALL, on a legal store, write only the addressed byte lanes: byte writes lane, half writes lanes {a1,a1+1}, word writes all four; writeData low bits are placed into the addressed lanes.
REQ-024 SHALL, on a legal store, commit memory at the accepting edge and respond with readData=0 and resp_err=0.
REQ-025 SHALL, on a legal load, return the selected lane(s) shifted to bit 0, then sign- or zero-extended per unsigned_ld (word ignores unsigned_ld).
REQ-026 SHALL return a load accepted the cycle after a store to the same word with the post-store data (no stale read).
REQ-027 SHALL keep memory contents as they are when INIT_ZERO=0; those contents are undefined after power-up and are not changed by rst.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, set resp_valid=0, resp_err=0 and readData=0, and drop any held response.
REQ-029 SHALL ignore a request presented during the reset cycle.
REQ-030 SHALL, when INIT_ZERO=1, assert busy_init for DEPTH cycles after rst falls: counter 0..DEPTH-1 writes zero, and req_ready=0 throughout; rst reasserted mid-init restarts the count at 0.
REQ-031 SHALL, when INIT_ZERO=0, assert req_ready in the first cycle after rst deasserts.

Verification
REQ-032 SHALL be verified as follows: word store 0xDEADBEEF at 0x10, then word load 0x10 -> resp_valid next cycle, readData=0xDEADBEEF, resp_err=0.
REQ-033 SHALL be verified as follows: byte store 0x80 at 0x13, then signed byte load 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word load 0x10 -> 0x80ADBEEF.
REQ-034 SHALL be verified as follows: half load at 0x11, word store at 0x12, and size=11 -> each gives resp_err=1 and readData=0, and a later word load 0x10 is unchanged.
REQ-035 SHALL be verified as follows: with DEPTH=256, a load at 0x400 -> resp_err=1.
REQ-036 SHALL be verified as follows: hold resp_ready=0 for 3 cycles after a load -> req_ready=0, readData stable; resp_ready=1 -> response pops and a new request is accepted the same cycle.
REQ-037 SHALL be verified as follows: rst asserted with resp_valid=1 -> resp_valid=0 next cycle; with INIT_ZERO=1, req_ready stays low for DEPTH cycles and any load then returns 0.

Source files
------------

// File: rtl/data_memory_sized.sv
// Byte-addressable little-endian data memory with a valid/ready request port and a
// one-entry response buffer; supports byte/half/word loads and stores with error flagging.
module data_memory_sized #(
    parameter int DEPTH     = 256,
    parameter bit INIT_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemWrite,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] readData,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    logic [31:0]   mem [DEPTH];
    logic          busy_init;
    logic [AW-1:0] init_cnt;
    logic          init_we;

    size_e         sz;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          accept;
    logic          req_err;
    logic [3:0]    be;
    logic [31:0]   wdata;

    logic          resp_load;
    logic [31:0]   rd_word;
    size_e         rd_size;
    logic [1:0]    rd_lane;
    logic          rd_uns;

    assign sz        = size_e'(size);
    assign idx       = address[AW+1:2];
    assign lane      = address[1:0];
    assign req_ready = !busy_init && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready && !rst;
    assign init_we   = busy_init && !rst;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        req_err = (address[31:AW+2] != '0);
        unique case (sz)
            SZ_HALF: if (lane[0])       req_err = 1'b1;
            SZ_WORD: if (lane != 2'b00) req_err = 1'b1;
            SZ_ILL:                     req_err = 1'b1;
            default: ;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be    = '0;
        wdata = '0;
        unique case (sz)
            SZ_BYTE: begin
                be    = 4'b0001 << lane;
                wdata = {4{writeData[7:0]}};
            end
            SZ_HALF: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{writeData[15:0]}};
            end
            SZ_WORD: begin
                be    = 4'b1111;
                wdata = writeData;
            end
            default: ;
        endcase
        if (!(accept && MemWrite && !req_err)) be = '0;
    end

    if (INIT_ZERO) begin : g_init
        always_ff @(posedge clk) begin
            if (rst) begin
                busy_init <= 1'b1;
                init_cnt  <= '0;
            end else if (busy_init) begin
                if (init_cnt == AW'(DEPTH - 1)) busy_init <= 1'b0;
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end else begin : g_no_init
        assign busy_init = 1'b0;
        assign init_cnt  = '0;
    end

    // NOTE: the storage array and read-data path carry no reset, so they map onto RAM.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_cnt] <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (accept) begin
            rd_word <= mem[idx];
            rd_size <= sz;
            rd_lane <= lane;
            rd_uns  <= unsigned_ld;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_load  <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_err   <= req_err;
            resp_load  <= !MemWrite && !req_err;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    // Lane extraction and extension happen after the register, so a held response stays stable.
    always_comb begin
        logic [7:0]  b_sel;
        logic [15:0] h_sel;
        b_sel    = rd_word[8*rd_lane +: 8];
        h_sel    = rd_lane[1] ? rd_word[31:16] : rd_word[15:0];
        readData = '0;
        if (resp_load) begin
            unique case (rd_size)
                SZ_BYTE: readData = {{24{!rd_uns && b_sel[7]}}, b_sel};
                SZ_HALF: readData = {{16{!rd_uns && h_sel[15]}}, h_sel};
                default: readData = rd_word;
            endcase
        end
    end
endmodule
